// File: rtl/gpu_csr.sv
// gpu_csr: Avalon-MM register file in front of the render controller.
// Shadow/active frame parameters, start/ack pulses, busy/done tracking, irq.
package gpu_csr_pkg;
  localparam int CAM_COORD_BITS = 8;
  localparam int CAM_FRAC_BITS = 8;
  localparam int CAM_CW = CAM_COORD_BITS + CAM_FRAC_BITS;

  typedef struct packed {
    logic [CAM_CW-1:0] x;
    logic [CAM_CW-1:0] y;
    logic [CAM_CW-1:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t look0;
    vec3_t look1;
    vec3_t look2;
    vec3_t look3;
  } camera;
endpackage

module gpu_csr
  import gpu_csr_pkg::*;
#(
  parameter int COORD_BITS = CAM_COORD_BITS,
  parameter int FRAC_BITS = CAM_FRAC_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  s1_address,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [31:0] s1_writedata,
  output logic [31:0] s1_readdata,
  output logic [31:0] pixel_buffer,
  output logic [31:0] voxel_buffer,
  output logic [31:0] voxel_count,
  output logic [31:0] palette_buffer,
  output logic [31:0] palette_length,
  output camera       cam,
  output logic        do_render,
  output logic        clear_interrupt,
  input  logic        gpu_irq,
  output logic        irq
);
  localparam int CW = COORD_BITS + FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE, ACK_WAIT
  } state_t;

  state_t state, state_d;

  logic [31:0] pix_sh, vox_sh, cnt_sh, pal_sh, len_sh;
  logic [0:11][CW-1:0] cam_sh, cam_act;
  logic [31:0] frame_count;
  logic        irq_en, dropped, gpu_irq_q;
  logic        busy, irq_pending, irq_rise;
  logic        wr_ctrl, start, ack;
  logic        go, clr, drop, fc_inc;
  logic        cam_hit;
  logic [3:0]  cam_idx;
  logic [31:0] rdata;

  assign cam = camera'(cam_act);
  assign busy = (state == BUSY) || (state == ACK_WAIT);
  assign irq_pending = (state == DONE);
  assign irq_rise = gpu_irq & ~gpu_irq_q;
  assign wr_ctrl = s1_write && (s1_address == 5'd0);
  assign start = wr_ctrl & s1_writedata[0];
  assign ack = wr_ctrl & s1_writedata[1];
  assign cam_hit = (s1_address >= 5'd8) && (s1_address <= 5'd19);
  assign cam_idx = 4'(s1_address - 5'd8);

  always_comb begin
    state_d = state;
    go = 1'b0;
    clr = 1'b0;
    drop = 1'b0;
    fc_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          go = 1'b1;
        end
      end
      BUSY: begin
        if (start) drop = 1'b1;
        if (irq_rise) begin
          state_d = DONE;
          fc_inc = 1'b1;
        end
      end
      DONE: begin
        if (ack) begin
          clr = 1'b1;
          state_d = start ? ACK_WAIT : IDLE;
        end else if (start) begin
          drop = 1'b1;
        end
      end
      ACK_WAIT: begin
        // controller is back in idle now; launch the deferred frame
        state_d = BUSY;
        go = 1'b1;
        if (start) drop = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (s1_address)
      5'd0: rdata = {28'b0, dropped, irq_en, irq_pending, busy};
      5'd1: rdata = pix_sh;
      5'd2: rdata = vox_sh;
      5'd3: rdata = cnt_sh;
      5'd4: rdata = pal_sh;
      5'd5: rdata = len_sh;
      5'd6: rdata = frame_count;
      default: begin
        if (cam_hit) rdata = {{(32-CW){1'b0}}, cam_sh[cam_idx]};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_sh <= '0;
      vox_sh <= '0;
      cnt_sh <= '0;
      pal_sh <= '0;
      len_sh <= '0;
      cam_sh <= '0;
      pixel_buffer <= '0;
      voxel_buffer <= '0;
      voxel_count <= '0;
      palette_buffer <= '0;
      palette_length <= '0;
      cam_act <= '0;
      frame_count <= '0;
      irq_en <= 1'b0;
      dropped <= 1'b0;
      gpu_irq_q <= 1'b0;
      do_render <= 1'b0;
      clear_interrupt <= 1'b0;
      irq <= 1'b0;
      s1_readdata <= '0;
    end else begin
      gpu_irq_q <= gpu_irq;
      do_render <= go;
      clear_interrupt <= clr;
      irq <= irq_pending & irq_en;
      s1_readdata <= s1_read ? rdata : '0;
      if (fc_inc) frame_count <= frame_count + 32'd1;
      if (wr_ctrl) irq_en <= s1_writedata[2];
      if (drop) dropped <= 1'b1;
      else if (wr_ctrl && s1_writedata[3]) dropped <= 1'b0;
      if (s1_write) begin
        unique case (s1_address)
          5'd1: pix_sh <= s1_writedata;
          5'd2: vox_sh <= s1_writedata;
          5'd3: cnt_sh <= s1_writedata;
          5'd4: pal_sh <= s1_writedata;
          5'd5: len_sh <= s1_writedata;
          default: begin
            if (cam_hit) cam_sh[cam_idx] <= s1_writedata[CW-1:0];
          end
        endcase
      end
      // active set sees the shadows as they were before this edge
      if (go) begin
        pixel_buffer <= pix_sh;
        voxel_buffer <= vox_sh;
        voxel_count <= cnt_sh;
        palette_buffer <= pal_sh;
        palette_length <= len_sh;
        cam_act <= cam_sh;
      end
    end
  end
endmodule

// File: tb/tb_gpu_csr.sv
// tb_gpu_csr: directed self-checking bench for gpu_csr.
// Each task drives one scenario and checks against hand-computed values.
module tb_gpu_csr;
  import gpu_csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  s1_address = '0;
  logic        s1_read = 1'b0;
  logic        s1_write = 1'b0;
  logic [31:0] s1_writedata = '0;
  logic [31:0] s1_readdata;
  logic [31:0] pixel_buffer, voxel_buffer, voxel_count;
  logic [31:0] palette_buffer, palette_length;
  camera       cam;
  logic        do_render, clear_interrupt;
  logic        gpu_irq = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  gpu_csr #(.COORD_BITS(8), .FRAC_BITS(8)) dut (
    .clock(clock),
    .reset(reset),
    .s1_address(s1_address),
    .s1_read(s1_read),
    .s1_write(s1_write),
    .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata),
    .pixel_buffer(pixel_buffer),
    .voxel_buffer(voxel_buffer),
    .voxel_count(voxel_count),
    .palette_buffer(palette_buffer),
    .palette_length(palette_length),
    .cam(cam),
    .do_render(do_render),
    .clear_interrupt(clear_interrupt),
    .gpu_irq(gpu_irq),
    .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    s1_address = a;
    s1_writedata = d;
    s1_write = 1'b1;
    @(posedge clock);
    #1;
    s1_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clock);
    s1_address = a;
    s1_read = 1'b1;
    @(posedge clock);
    #1;
    s1_read = 1'b0;
    d = s1_readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    checks++;
    if ({do_render, clear_interrupt, irq} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000",
               {do_render, clear_interrupt, irq});
    end
    checks++;
    if ({pixel_buffer, voxel_count, s1_readdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0",
               {pixel_buffer, voxel_count, s1_readdata});
    end
    @(negedge clock);
    reset = 1'b0;
    rd(5'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_control: got %h want 0", d);
    end
  endtask

  task automatic test_start;
    logic [31:0] d;
    wr(5'd1, 32'h0800_0000);
    wr(5'd3, 32'h0000_1000);
    wr(5'd15, 32'h0000_1234);
    wr(5'd0, 32'h1);
    checks++;
    if (do_render !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse: got %b want 1", do_render);
    end
    checks++;
    if (pixel_buffer !== 32'h0800_0000 || voxel_count !== 32'h1000) begin
      errors++;
      $display("FAIL start_active: got %h/%h want 08000000/00001000",
               pixel_buffer, voxel_count);
    end
    checks++;
    if (cam.look2.y !== 16'h1234) begin
      errors++;
      $display("FAIL start_cam: got %h want 1234", cam.look2.y);
    end
    @(posedge clock);
    #1;
    checks++;
    if (do_render !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse_len: got %b want 0", do_render);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL start_busy: got %h want 1", d);
    end
  endtask

  task automatic test_busy_irq;
    logic [31:0] d;
    wr(5'd3, 32'd5);
    checks++;
    if (voxel_count !== 32'h1000) begin
      errors++;
      $display("FAIL busy_shadow: got %h want 00001000", voxel_count);
    end
    wr(5'd0, 32'h4);
    @(negedge clock);
    gpu_irq = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b want 0", irq);
    end
    @(posedge clock);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_raise: got %b want 1", irq);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL done_control: got %h want 6", d);
    end
    rd(5'd6, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL frame_count: got %h want 1", d);
    end
  endtask

  task automatic test_drop_and_deferred;
    logic [31:0] d;
    wr(5'd0, 32'h5);
    checks++;
    if (do_render !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: got %b want 0", do_render);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'he) begin
      errors++;
      $display("FAIL drop_set: got %h want e", d);
    end
    wr(5'd0, 32'hc);
    rd(5'd0, d);
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL drop_clear: got %h want 6", d);
    end
    wr(5'd0, 32'h7);
    checks++;
    if ({clear_interrupt, do_render} !== 2'b10) begin
      errors++;
      $display("FAIL defer_t: got %b want 10",
               {clear_interrupt, do_render});
    end
    gpu_irq = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({clear_interrupt, do_render, irq} !== 3'b010) begin
      errors++;
      $display("FAIL defer_t1: got %b want 010",
               {clear_interrupt, do_render, irq});
    end
    checks++;
    if (voxel_count !== 32'd5) begin
      errors++;
      $display("FAIL defer_active: got %h want 5", voxel_count);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL defer_busy: got %h want 5", d);
    end
    wr(5'd0, 32'h6);
    checks++;
    if (clear_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: got %b want 0", clear_interrupt);
    end
    wr(5'd0, 32'h5);
    checks++;
    if (do_render !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got %b want 0", do_render);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'hd) begin
      errors++;
      $display("FAIL busy_drop: got %h want d", d);
    end
    wr(5'd0, 32'hc);
    rd(5'd0, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL busy_drop_clear: got %h want 5", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    @(negedge clock);
    gpu_irq = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mid_irq: got %b want 1", irq);
    end
    @(negedge clock);
    reset = 1'b1;
    gpu_irq = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({irq, do_render, clear_interrupt} !== 3'b000) begin
      errors++;
      $display("FAIL mid_pulses: got %b want 000",
               {irq, do_render, clear_interrupt});
    end
    checks++;
    if ({s1_readdata, pixel_buffer, voxel_count} !== 96'd0 || cam !== '0) begin
      errors++;
      $display("FAIL mid_regs: got %h/%h/%h want 0",
               s1_readdata, pixel_buffer, voxel_count);
    end
    @(negedge clock);
    reset = 1'b0;
    rd(5'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_control: got %h want 0", d);
    end
    rd(5'd6, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_fcount: got %h want 0", d);
    end
    wr(5'd0, 32'h1);
    checks++;
    if (do_render !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: got %b want 1", do_render);
    end
  endtask

  task automatic test_map;
    logic [31:0] d;
    rd(5'd7, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr7: got %h want 0", d);
    end
    wr(5'd7, 32'hffff_ffff);
    rd(5'd7, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr7_wr: got %h want 0", d);
    end
    wr(5'd25, 32'h1234_5678);
    rd(5'd25, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr25: got %h want 0", d);
    end
    wr(5'd8, 32'hffff_abcd);
    rd(5'd8, d);
    checks++;
    if (d !== 32'h0000_abcd) begin
      errors++;
      $display("FAIL cam_rd: got %h want 0000abcd", d);
    end
    checks++;
    if (cam.look0.x !== 16'h0) begin
      errors++;
      $display("FAIL cam_active: got %h want 0", cam.look0.x);
    end
    wr(5'd2, 32'hdead_beef);
    rd(5'd2, d);
    checks++;
    if (d !== 32'hdead_beef) begin
      errors++;
      $display("FAIL vox_buf_rd: got %h want deadbeef", d);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_busy_irq();
    test_drop_and_deferred();
    test_reset_mid();
    test_map();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
